program_loader: RTL
===================

# program_loader

Boot-time writer for the instruction memory's program-write port. It accepts a byte stream from the off-chip link and assembles little-endian halfword instructions. It drives `program_mem_write_en`, `instruction`, and `instruction_addr` into the instruction memory while holding the CPU core in reset. Once a complete image has been written and its checksum verified, it releases the core.

## Interface
Parameters:
- `MAX_HALFWORDS`, 512: capacity of the instruction memory in halfwords. The image length must not exceed this value.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `byte_i`  in  8  incoming stream byte.
- `byte_valid_i`  in  1  `byte_i` is valid this cycle.
- `byte_ready_o`  out  1  loader accepts a byte this cycle. A transfer occurs when `byte_valid_i` and `byte_ready_o` are both high.
- `load_start_i`  in  1  pulse; restarts loading. Honoured only in DONE or ERROR.
- `program_mem_write_en_o`  out  1  one-cycle write strobe to instruction memory.
- `instruction_o`  out  HALF_WORD  halfword to write.
- `instruction_addr_o`  out  WORD  byte address of the write. Always even.
- `cpu_reset_o`  out  1  holds the core, including the pipeline valid bits, in reset.
- `load_done_o`  out  1  image loaded and checksum good.
- `load_error_o`  out  1  length overflow or checksum mismatch.

## Operation
- Stream format, in order:
  - LEN_LO, LEN_HI: 16-bit halfword count N.
  - N × (DATA_LO, DATA_HI).
  - CSUM: one byte equal to the XOR of all data bytes. Length bytes are excluded from the checksum.
- States and transitions:
  - LEN_LO → LEN_HI: on a byte transfer.
  - LEN_HI → ERROR: if {byte, len_lo} > MAX_HALFWORDS.
  - LEN_HI → CSUM: if N = 0.
  - LEN_HI → DATA_LO: otherwise.
  - DATA_LO → DATA_HI: on a byte transfer.
  - DATA_HI → WRITE: on a byte transfer.
  - WRITE → CSUM: if this is the last halfword (remaining count = 1).
  - WRITE → DATA_LO: otherwise. WRITE lasts exactly one cycle.
  - CSUM → DONE: if the received byte equals the running XOR.
  - CSUM → ERROR: otherwise.
  - DONE / ERROR → LEN_LO: on `load_start_i`.
- `byte_ready_o` = 1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI, and CSUM. It is 0 in WRITE, DONE, and ERROR.
- In WRITE:
  - `program_mem_write_en_o` = 1.
  - `instruction_o` = {hi_byte, lo_byte}.
  - `instruction_addr_o` = current address.
  - The address increments by 2 on the cycle after WRITE. The remaining count decrements by 1.
- Outside WRITE, `program_mem_write_en_o` = 0. `instruction_o` and `instruction_addr_o` hold their last values.
- Address arithmetic is WORD-wide and starts at 0. N ≤ MAX_HALFWORDS, so the address cannot wrap.
- `cpu_reset_o` = 1 in every state except DONE.
- `load_done_o` = 1 only in DONE. `load_error_o` = 1 only in ERROR.
- Memory contents written before an ERROR are not rolled back. The core stays in reset.
- Entry into LEN_LO (from reset or `load_start_i`) clears the address, the remaining count, and the running XOR.

## Timing
- Reset values: state LEN_LO, `byte_ready_o` = 1, `program_mem_write_en_o` = 0, `instruction_o` = 0, `instruction_addr_o` = 0, `cpu_reset_o` = 1, `load_done_o` = 0, `load_error_o` = 0.
- All outputs are registered or decoded from the state register. There is no combinational path from `byte_valid_i` to any output.
- Write latency: the strobe is asserted in the cycle after the DATA_HI transfer edge.
- Minimum of 3 cycles per halfword. Byte gaps (`byte_valid_i` low) stall the loader in its current state with no side effects.
- DONE is entered on the edge that accepts a matching CSUM byte. At that edge `cpu_reset_o` falls and `load_done_o` rises.
- `load_start_i` in any state other than DONE or ERROR is ignored.
- `reset_i` dominates everything. Reset mid-image returns to LEN_LO and drops any pending write.
- `load_start_i` and `reset_i` asserted together: the result is the reset values.

## Test plan
- N=2, data 0x34,0x12,0x78,0x56, CSUM 0x08 → writes 0x1234@0x0 then 0x5678@0x2. Then DONE, `cpu_reset_o` = 0.
- Same image with CSUM 0x09 → both writes occur, then ERROR, `load_error_o` = 1, `cpu_reset_o` stays 1.
- LEN = 0x0201 (513) with MAX_HALFWORDS = 512 → ERROR right after LEN_HI, no writes.
- N=0, CSUM 0x00 → DONE with no write strobe. With CSUM 0x01 instead → ERROR.
- N=3 with `byte_valid_i` toggled randomly, then `reset_i` asserted after the second write → outputs return to reset values. A fresh N=1 image then writes at address 0x0.
- From DONE, pulse `load_start_i` → `cpu_reset_o` = 1 and `load_done_o` = 0 next cycle. A new image loads from address 0.

Source files
------------

// File: rtl/program_loader_if.sv
// Boot-loader bus: the inbound byte stream handshake plus the instruction-memory write port.
interface program_loader_if #(
    parameter int HALF_WORD = 16,
    parameter int WORD      = 32
);
    logic [7:0]           byte_i;
    logic                 byte_valid_i;
    logic                 byte_ready_o;
    logic                 program_mem_write_en_o;
    logic [HALF_WORD-1:0] instruction_o;
    logic [WORD-1:0]      instruction_addr_o;

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output program_mem_write_en_o,
        output instruction_o,
        output instruction_addr_o
    );

    modport master (
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  program_mem_write_en_o,
        input  instruction_o,
        input  instruction_addr_o
    );
endinterface

// File: rtl/program_loader.sv
// Assembles a little-endian halfword image from a byte stream, writes it to instruction
// memory and releases the core once the XOR checksum of the data bytes matches.
module program_loader #(
    parameter int MAX_HALFWORDS = 512
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_start_i,
    program_loader_if.slave    bus,
    output logic               cpu_reset_o,
    output logic               load_done_o,
    output logic               load_error_o
);
    localparam int HALF_WORD = 16;
    localparam int WORD      = 32;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [7:0]           r_lenLo;
    logic [7:0]           r_loByte;
    logic [7:0]           r_xor;
    logic [15:0]          r_remaining;
    logic [WORD-1:0]      r_addr;
    logic [WORD-1:0]      r_instrAddr;
    logic [HALF_WORD-1:0] r_instr;
    logic                 w_ready;
    logic                 w_xfer;
    logic [15:0]          w_len;

    assign w_ready = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA_LO) ||
                     (r_state == DATA_HI) || (r_state == CSUM);
    assign w_xfer  = w_ready && bus.byte_valid_i;
    assign w_len   = {bus.byte_i, r_lenLo};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= LEN_LO;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            LEN_LO:  if (w_xfer) w_nextState = LEN_HI;
            LEN_HI: begin
                if (w_xfer) begin
                    if (int'(w_len) > MAX_HALFWORDS) begin
                        w_nextState = ERROR;
                    end else if (w_len == 16'd0) begin
                        w_nextState = CSUM;
                    end else begin
                        w_nextState = DATA_LO;
                    end
                end
            end
            DATA_LO: if (w_xfer) w_nextState = DATA_HI;
            DATA_HI: if (w_xfer) w_nextState = WRITE;
            WRITE:   w_nextState = (r_remaining == 16'd1) ? CSUM : DATA_LO;
            CSUM: begin
                if (w_xfer) begin
                    w_nextState = (bus.byte_i == r_xor) ? DONE : ERROR;
                end
            end
            DONE:    if (load_start_i) w_nextState = LEN_LO;
            ERROR:   if (load_start_i) w_nextState = LEN_LO;
            default: w_nextState = LEN_LO;
        endcase
    end

    // The output address register is captured separately so the running address can
    // advance after WRITE without disturbing the value held on the memory port.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_lenLo     <= '0;
            r_loByte    <= '0;
            r_xor       <= '0;
            r_remaining <= '0;
            r_addr      <= '0;
            r_instrAddr <= '0;
            r_instr     <= '0;
        end else begin
            case (r_state)
                LEN_LO: begin
                    if (w_xfer) r_lenLo <= bus.byte_i;
                end
                LEN_HI: begin
                    if (w_xfer) r_remaining <= w_len;
                end
                DATA_LO: begin
                    if (w_xfer) begin
                        r_loByte <= bus.byte_i;
                        r_xor    <= r_xor ^ bus.byte_i;
                    end
                end
                DATA_HI: begin
                    if (w_xfer) begin
                        r_instr     <= {bus.byte_i, r_loByte};
                        r_instrAddr <= r_addr;
                        r_xor       <= r_xor ^ bus.byte_i;
                    end
                end
                WRITE: begin
                    r_addr      <= r_addr + WORD'(2);
                    r_remaining <= r_remaining - 16'd1;
                end
                DONE, ERROR: begin
                    if (load_start_i) begin
                        r_addr      <= '0;
                        r_remaining <= '0;
                        r_xor       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready_o           = w_ready;
    assign bus.program_mem_write_en_o = (r_state == WRITE);
    assign bus.instruction_o          = r_instr;
    assign bus.instruction_addr_o     = r_instrAddr;
    assign cpu_reset_o                = (r_state != DONE);
    assign load_done_o                = (r_state == DONE);
    assign load_error_o               = (r_state == ERROR);
endmodule
